dcp_tag_xbar: RTL and testbench

Parametrised N_IN x N_OUT tag crossbar with decoupled (Vld/Rdy) ports. It routes packet tags (priority, buffer address + length, source port) from the ingress tag ports to per-destination egress queues. It is the generalised successor of the fixed 16x16 tag crossbar:
- configurable port counts and payload width;
- per-output round-robin arbitration and per-output FIFO buffering;
- out-of-range destination drop;
- optional priority-aware arbitration.

---
 rtl/dcp_tag_xbar.sv | 167 ++++++++++++++++
 tb/tb_dcp_tag_xbar.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/dcp_tag_xbar.sv
`default_nettype none
//==============================================================================
// Module   : dcp_tag_xbar
// Purpose  : N_IN x N_OUT tag crossbar, round-robin arbiter and FIFO per output.
// Option   : XBAR_PRI_ARB_EN selects priority-masked round-robin arbitration.
// Revision : 1.0 - initial parametrised release
//==============================================================================
`ifndef ADDR_LENTH
`define ADDR_LENTH 21
`endif

module dcp_tag_xbar #(
  parameter int N_IN  = 16,
  parameter int N_OUT = 16,
  parameter int DW    = `ADDR_LENTH + 11,
  parameter int DEPTH = 4,
  parameter int DSTW  = (N_OUT > 1) ? $clog2(N_OUT) : 1,
  parameter int SRCW  = (N_IN > 1) ? $clog2(N_IN) : 1
) (
  input  logic                  iClk,
  input  logic                  iRst_n,
  input  logic [N_IN-1:0]       iTagVld,
  output logic [N_IN-1:0]       oTagRdy,
  input  logic [N_IN*DSTW-1:0]  iTagDst,
  input  logic [N_IN*DW-1:0]    iTagPld,
  output logic [N_OUT-1:0]      oTagVld,
  input  logic [N_OUT-1:0]      iTagRdy,
  output logic [N_OUT*DW-1:0]   oTagPld,
  output logic [N_OUT*SRCW-1:0] oTagSrc,
  output logic [N_IN-1:0]       oDrop
);

  localparam int AW = $clog2(DEPTH);
  localparam int EW = DW + SRCW;
  localparam logic [DSTW:0] C_NOUT  = (DSTW+1)'(N_OUT);
  localparam logic [AW:0]   C_DEPTH = (AW+1)'(DEPTH);

  logic [DSTW-1:0] w_dst    [N_IN];
  logic [DW-1:0]   w_pld    [N_IN];
  logic [N_IN-1:0] w_req    [N_OUT];
  logic [N_IN-1:0] w_cand   [N_OUT];
  logic [SRCW-1:0] w_gntIdx [N_OUT];
  logic [SRCW-1:0] w_ptr    [N_OUT];
  logic [N_OUT-1:0] w_gntVld;
  logic [N_OUT-1:0] w_notFull;
  logic [N_IN-1:0]  w_gntIn;
  logic [N_IN-1:0]  w_isDrop;
  logic [N_IN-1:0]  r_drop;

  genvar gi, gj;
  generate
    for (gi = 0; gi < N_IN; gi++) begin : g_in
      assign w_dst[gi]    = iTagDst[gi*DSTW +: DSTW];
      assign w_pld[gi]    = iTagPld[gi*DW +: DW];
      assign w_isDrop[gi] = {1'b0, w_dst[gi]} >= C_NOUT;
    end
  endgenerate

  always_comb begin
    for (int j = 0; j < N_OUT; j++) begin
      for (int i = 0; i < N_IN; i++) begin
        w_req[j][i] = iTagVld[i] && ({1'b0, w_dst[i]} == (DSTW+1)'(j));
      end
    end
  end

`ifdef XBAR_PRI_ARB_EN
  // Keep only the requesters carrying the highest pri field for this output.
  logic [2:0] w_maxPri [N_OUT];
  always_comb begin
    for (int j = 0; j < N_OUT; j++) begin
      w_maxPri[j] = 3'd0;
      w_cand[j]   = '0;
      for (int i = 0; i < N_IN; i++) begin
        if (w_req[j][i] && (w_pld[i][DW-1:DW-3] > w_maxPri[j])) w_maxPri[j] = w_pld[i][DW-1:DW-3];
      end
      for (int i = 0; i < N_IN; i++) begin
        w_cand[j][i] = w_req[j][i] && (w_pld[i][DW-1:DW-3] == w_maxPri[j]);
      end
    end
  end
`else
  always_comb begin
    for (int j = 0; j < N_OUT; j++) w_cand[j] = w_req[j];
  end
`endif

  // Scan from the farthest offset back to the pointer so the closest requester wins.
  always_comb begin
    logic [SRCW-1:0] idx;
    idx = '0;
    for (int j = 0; j < N_OUT; j++) begin
      w_gntVld[j] = 1'b0;
      w_gntIdx[j] = '0;
      for (int k = N_IN-1; k >= 0; k--) begin
        idx = SRCW'((int'(w_ptr[j]) + k) % N_IN);
        if (w_cand[j][idx]) begin
          w_gntIdx[j] = idx;
          w_gntVld[j] = w_notFull[j];
        end
      end
    end
  end

  always_comb begin
    w_gntIn = '0;
    for (int i = 0; i < N_IN; i++) begin
      for (int j = 0; j < N_OUT; j++) begin
        if (w_gntVld[j] && (w_gntIdx[j] == SRCW'(i))) w_gntIn[i] = 1'b1;
      end
    end
  end

  assign oTagRdy = iRst_n ? (w_gntIn | w_isDrop) : '0;
  assign oDrop   = r_drop;

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) r_drop <= '0;
    else         r_drop <= iTagVld & w_isDrop;
  end

  generate
    for (gj = 0; gj < N_OUT; gj++) begin : g_out
      logic [EW-1:0]   r_mem [DEPTH];
      logic [AW-1:0]   r_wp;
      logic [AW-1:0]   r_rp;
      logic [AW:0]     r_count;
      logic [SRCW-1:0] r_ptr;
      logic            w_push;
      logic            w_pop;
      logic [EW-1:0]   w_head;

      assign w_push         = w_gntVld[gj];
      assign w_pop          = oTagVld[gj] && iTagRdy[gj];
      assign w_notFull[gj]  = r_count < C_DEPTH;
      assign w_ptr[gj]      = r_ptr;
      assign w_head         = r_mem[r_rp];
      assign oTagVld[gj]    = r_count != '0;
      assign oTagPld[gj*DW +: DW]     = w_head[EW-1:SRCW];
      assign oTagSrc[gj*SRCW +: SRCW] = w_head[SRCW-1:0];

      always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
          r_wp    <= '0;
          r_rp    <= '0;
          r_count <= '0;
          r_ptr   <= '0;
          for (int d = 0; d < DEPTH; d++) r_mem[d] <= '0;
        end else begin
          if (w_push) begin
            r_mem[r_wp] <= {w_pld[w_gntIdx[gj]], w_gntIdx[gj]};
            r_wp        <= r_wp + AW'(1);
            r_ptr       <= (w_gntIdx[gj] == SRCW'(N_IN-1)) ? '0 : w_gntIdx[gj] + SRCW'(1);
          end
          if (w_pop) r_rp <= r_rp + AW'(1);
          case ({w_push, w_pop})
            2'b10:   r_count <= r_count + (AW+1)'(1);
            2'b01:   r_count <= r_count - (AW+1)'(1);
            default: r_count <= r_count;
          endcase
        end
      end
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_dcp_tag_xbar.sv
`default_nettype none
// Randomized scoreboard bench: expected tags are queued per output by a reference
// model of the arbitration rules and popped by a monitor on each egress handshake.
module tb_dcp_tag_xbar;
  localparam int N_IN = 8, N_OUT = 12, DW = 16, DEPTH = 4, DSTW = 4, SRCW = 3;

  logic                  iClk = 1'b0;
  logic                  iRst_n = 1'b1;
  logic [N_IN-1:0]       iTagVld = '0;
  logic [N_IN-1:0]       oTagRdy;
  logic [N_IN*DSTW-1:0]  iTagDst = '0;
  logic [N_IN*DW-1:0]    iTagPld = '0;
  logic [N_OUT-1:0]      oTagVld;
  logic [N_OUT-1:0]      iTagRdy = '1;
  logic [N_OUT*DW-1:0]   oTagPld;
  logic [N_OUT*SRCW-1:0] oTagSrc;
  logic [N_IN-1:0]       oDrop;

  always #5 iClk = ~iClk;

  dcp_tag_xbar #(.N_IN(N_IN), .N_OUT(N_OUT), .DW(DW), .DEPTH(DEPTH), .DSTW(DSTW), .SRCW(SRCW)) dut (
    .iClk(iClk), .iRst_n(iRst_n), .iTagVld(iTagVld), .oTagRdy(oTagRdy), .iTagDst(iTagDst),
    .iTagPld(iTagPld), .oTagVld(oTagVld), .iTagRdy(iTagRdy), .oTagPld(oTagPld),
    .oTagSrc(oTagSrc), .oDrop(oDrop)
  );

  typedef struct packed {
    logic [DW-1:0]   pld;
    logic [SRCW-1:0] src;
  } tag_t;

  tag_t expQ [N_OUT][$];
  int   ptrM [N_OUT];
  int   nTests = 0;
  int   nFail = 0;

  function automatic void check(string nm, logic [63:0] act, logic [63:0] exp);
    nTests++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endfunction

  // Monitor: every egress handshake must deliver the oldest expected tag of that output.
  initial begin
    tag_t e;
    forever begin
      @(negedge iClk);
      #2;
      if (iRst_n) begin
        for (int j = 0; j < N_OUT; j++) begin
          if (oTagVld[j] && iTagRdy[j]) begin
            if (expQ[j].size() == 0) begin
              nTests++;
              nFail++;
              $display("FAIL pop_empty: output %0d presented a tag, expected none", j);
            end else begin
              e = expQ[j].pop_front();
              check("egress_pld", 64'(oTagPld[j*DW +: DW]), 64'(e.pld));
              check("egress_src", 64'(oTagSrc[j*SRCW +: SRCW]), 64'(e.src));
            end
          end
        end
      end
    end
  end

  // Stimulus and reference model.
  initial begin
    logic [N_IN-1:0]  accM, expDrop, gnt, dropMask, rdyExp;
    logic [N_OUT-1:0] vldExp;
    int vp, rp, hot, best, bestD, maxP, d, dst, pri;
    tag_t t;
    accM = '0; expDrop = '0;
    for (int j = 0; j < N_OUT; j++) ptrM[j] = 0;

    #1 iRst_n = 1'b0;
    #1;
    check("rst_oTagVld", 64'(oTagVld), 64'd0);
    check("rst_oTagRdy", 64'(oTagRdy), 64'd0);
    check("rst_oDrop",   64'(oDrop),   64'd0);
    check("rst_oTagPld", 64'(|oTagPld), 64'd0);
    check("rst_oTagSrc", 64'(|oTagSrc), 64'd0);
    repeat (2) @(negedge iClk);
    iRst_n = 1'b1;

    for (int cyc = 0; cyc < 2000; cyc++) begin
      @(negedge iClk);
      if (cyc == 1500) begin
        iRst_n = 1'b0;
        #1;
        check("midrst_oTagVld", 64'(oTagVld), 64'd0);
        check("midrst_oTagRdy", 64'(oTagRdy), 64'd0);
        for (int j = 0; j < N_OUT; j++) begin
          expQ[j].delete();
          ptrM[j] = 0;
        end
        expDrop = '0; accM = '0; iTagVld = '0;
        repeat (2) @(negedge iClk);
        check("midrst_oTagPld", 64'(|oTagPld), 64'd0);
        iRst_n = 1'b1;
      end

      if (cyc < 400)       begin vp = 60; rp = 80;  hot = 0; end
      else if (cyc < 800)  begin vp = 90; rp = 100; hot = 1; end
      else if (cyc < 1200) begin vp = 70; rp = 20;  hot = 0; end
      else if (cyc < 1500) begin vp = 70; rp = 0;   hot = 0; end
      else                 begin vp = 60; rp = 70;  hot = 0; end

      for (int i = 0; i < N_IN; i++) begin
        if (!iTagVld[i] || accM[i]) begin
          iTagVld[i] = ($urandom_range(0, 99) < vp);
          iTagDst[i*DSTW +: DSTW] = hot ? DSTW'($urandom_range(5, 6)) : DSTW'($urandom_range(0, 15));
          iTagPld[i*DW +: DW] = DW'($urandom);
        end
      end
      for (int j = 0; j < N_OUT; j++) iTagRdy[j] = ($urandom_range(0, 99) < rp);

      #1;
      check("oDrop", 64'(oDrop), 64'(expDrop));
      for (int j = 0; j < N_OUT; j++) vldExp[j] = (expQ[j].size() != 0);
      check("oTagVld", 64'(oTagVld), 64'(vldExp));

      gnt = '0;
      for (int i = 0; i < N_IN; i++) dropMask[i] = (int'(iTagDst[i*DSTW +: DSTW]) >= N_OUT);
      for (int j = 0; j < N_OUT; j++) begin
        maxP = -1;
`ifdef XBAR_PRI_ARB_EN
        for (int i = 0; i < N_IN; i++) begin
          pri = int'(iTagPld[i*DW + DW - 3 +: 3]);
          if (iTagVld[i] && int'(iTagDst[i*DSTW +: DSTW]) == j && pri > maxP) maxP = pri;
        end
`endif
        best = -1; bestD = N_IN;
        for (int i = 0; i < N_IN; i++) begin
          dst = int'(iTagDst[i*DSTW +: DSTW]);
          pri = int'(iTagPld[i*DW + DW - 3 +: 3]);
          if (iTagVld[i] && dst == j && (maxP < 0 || pri == maxP)) begin
            d = (i - ptrM[j] + N_IN) % N_IN;
            if (d < bestD) begin bestD = d; best = i; end
          end
        end
        if (best >= 0 && expQ[j].size() < DEPTH) begin
          gnt[best] = 1'b1;
          t.pld = iTagPld[best*DW +: DW];
          t.src = SRCW'(best);
          expQ[j].push_back(t);
          ptrM[j] = (best + 1) % N_IN;
        end
      end
      rdyExp = gnt | dropMask;
      check("oTagRdy", 64'(oTagRdy), 64'(rdyExp));
      expDrop = iTagVld & dropMask;
      accM = rdyExp & iTagVld;
    end

    repeat (2) @(negedge iClk);
    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end
endmodule
`default_nettype wire
